// File: rtl/alu_pkg.sv
// Shared constants and decoded-entry record for the ALU issue block.
// SLL/SLLI decode is enabled by defining ALU_ISSUE_SLL_EN.
package alu_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_BEQ  = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLTU = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_SLL  = 4'b1110;

  typedef struct packed {
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic [3:0]  alu_control;
    logic        illegal;
  } alu_entry_t;

  // Idle/reset value of an entry: ADD 0+0, not flagged.
  localparam alu_entry_t ENTRY_NOP = '{operand1: 32'd0, operand2: 32'd0,
                                       alu_control: ALU_ADD, illegal: 1'b0};

  function automatic logic [31:0] sext12(input logic [11:0] imm);
    return {{20{imm[11]}}, imm};
  endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32I subset decode into an ALU issue entry.
// SLL/SLLI are legal only when ALU_ISSUE_SLL_EN is defined.
import alu_pkg::*;

module alu_decode (
  input  logic [31:0] instr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output alu_entry_t  entry,
  output logic        legal
);

  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] operand2;
  logic [3:0]  alu_control;
  logic        sll_ok;
  logic        unused_rs1_field;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = sext12(instr[31:20]);
  assign imm_s  = sext12({instr[31:25], instr[11:7]});
  assign unused_rs1_field = ^instr[19:15];

`ifdef ALU_ISSUE_SLL_EN
  assign sll_ok = 1'b1;
`else
  assign sll_ok = 1'b0;
`endif

  always_comb begin
    legal       = 1'b0;
    alu_control = ALU_ADD;
    operand2    = rs2_data;
    case (opcode)
      OPC_OP: begin
        if (funct7 == F7_BASE) begin
          case (funct3)
            F3_ADD:  begin legal = 1'b1;   alu_control = ALU_ADD;  end
            F3_SLL:  begin legal = sll_ok; alu_control = ALU_SLL;  end
            F3_SLTU: begin legal = 1'b1;   alu_control = ALU_SLTU; end
            F3_OR:   begin legal = 1'b1;   alu_control = ALU_OR;   end
            F3_AND:  begin legal = 1'b1;   alu_control = ALU_AND;  end
            default: legal = 1'b0;
          endcase
        end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
          legal       = 1'b1;
          alu_control = ALU_SUB;
        end
      end
      OPC_OP_IMM: begin
        operand2 = imm_i;
        case (funct3)
          F3_ADD:  begin legal = 1'b1; alu_control = ALU_ADD;  end
          F3_SLTU: begin legal = 1'b1; alu_control = ALU_SLTU; end
          F3_OR:   begin legal = 1'b1; alu_control = ALU_OR;   end
          F3_AND:  begin legal = 1'b1; alu_control = ALU_AND;  end
          // Shift amount lands in operand2[4:0]; upper imm bits must be zero.
          F3_SLL: begin
            legal       = sll_ok && (funct7 == F7_BASE);
            alu_control = ALU_SLL;
          end
          default: legal = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        legal    = 1'b1;
        operand2 = imm_i;
      end
      OPC_STORE: begin
        legal    = 1'b1;
        operand2 = imm_s;
      end
      OPC_BRANCH: begin
        if (funct3 == F3_BEQ) begin
          legal       = 1'b1;
          alu_control = ALU_SUB;
        end
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    if (legal) begin
      entry = '{operand1: rs1_data, operand2: operand2,
                alu_control: alu_control, illegal: 1'b0};
    end else begin
      entry         = ENTRY_NOP;
      entry.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decode plus a 2-entry FIFO between upstream and the ALU.
// Config: define ALU_ISSUE_SLL_EN to decode SLL/SLLI.
import alu_pkg::*;

module alu_issue #(
  parameter int NOP_ON_ILLEGAL = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_rs1_data,
  input  logic [31:0] in_rs2_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_operand1,
  output logic [31:0] out_operand2,
  output logic [3:0]  out_alu_control,
  output logic        out_illegal
);

  localparam bit KEEP_ILLEGAL = (NOP_ON_ILLEGAL != 0);

  alu_entry_t dec_entry;
  logic       dec_legal;
  alu_entry_t entry_reg [2];
  alu_entry_t head;
  logic       rd_ptr_reg;
  logic       wr_ptr_reg;
  logic [1:0] count_reg;
  logic       push;
  logic       pop;

  alu_decode u_decode (
    .instr    (in_instr),
    .rs1_data (in_rs1_data),
    .rs2_data (in_rs2_data),
    .entry    (dec_entry),
    .legal    (dec_legal)
  );

  // Readiness depends on occupancy only, so out_ready never reaches in_ready.
  assign in_ready  = (count_reg != 2'd2);
  assign out_valid = (count_reg != 2'd0);

  // Dropped illegal instructions are still handshaken upstream.
  assign push = in_valid && in_ready && (dec_legal || KEEP_ILLEGAL);
  assign pop  = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg  <= 2'd0;
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        entry_reg[i] <= ENTRY_NOP;
      end
    end else begin
      if (push) begin
        entry_reg[wr_ptr_reg] <= dec_entry;
        wr_ptr_reg            <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head            = entry_reg[rd_ptr_reg];
  assign out_operand1    = head.operand1;
  assign out_operand2    = head.operand2;
  assign out_alu_control = head.alu_control;
  assign out_illegal     = head.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Directed scoreboard bench for alu_issue (default and drop-illegal instances).
// Expected SLL/SLLI results follow ALU_ISSUE_SLL_EN.
import alu_pkg::*;

module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = 32'd0;
  logic [31:0] in_rs1_data = 32'd0;
  logic [31:0] in_rs2_data = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_operand1;
  logic [31:0] out_operand2;
  logic [3:0]  out_alu_control;
  logic        out_illegal;

  logic        in_valid_z = 1'b0;
  logic        in_ready_z;
  logic        out_valid_z;
  logic [31:0] out_operand1_z;
  logic [31:0] out_operand2_z;
  logic [3:0]  out_alu_control_z;
  logic        out_illegal_z;

  int errors = 0;
  int checks = 0;
  alu_entry_t sb[$];
  alu_entry_t pend;

  always #5 clk = ~clk;

  alu_issue dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_operand1(out_operand1), .out_operand2(out_operand2),
    .out_alu_control(out_alu_control), .out_illegal(out_illegal)
  );

  alu_issue #(.NOP_ON_ILLEGAL(0)) dut_drop (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_z), .in_ready(in_ready_z), .in_instr(in_instr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .out_valid(out_valid_z), .out_ready(out_ready),
    .out_operand1(out_operand1_z), .out_operand2(out_operand2_z),
    .out_alu_control(out_alu_control_z), .out_illegal(out_illegal_z)
  );

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of the main DUT: compare against the scoreboard, then update it.
  task automatic cycle(output logic acc);
    logic exp_ready;
    #1;
    exp_ready = (sb.size() < 2);
    check("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
    check("out_valid", {31'd0, out_valid}, {31'd0, sb.size() != 0});
    if (sb.size() != 0) begin
      check("operand1", out_operand1, sb[0].operand1);
      check("operand2", out_operand2, sb[0].operand2);
      check("alu_control", {28'd0, out_alu_control}, {28'd0, sb[0].alu_control});
      check("illegal", {31'd0, out_illegal}, {31'd0, sb[0].illegal});
      if (out_ready) begin
        $display("issue op1=%h op2=%h ctrl=%b ill=%b", out_operand1, out_operand2,
                 out_alu_control, out_illegal);
        void'(sb.pop_front());
      end
    end
    acc = in_valid && exp_ready;
    if (acc) sb.push_back(pend);
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2,
                      input logic [31:0] e1, input logic [31:0] e2, input logic [3:0] ec,
                      input logic ei);
    logic acc;
    in_valid    = 1'b1;
    in_instr    = instr;
    in_rs1_data = rs1;
    in_rs2_data = rs2;
    pend = '{operand1: e1, operand2: e2, alu_control: ec, illegal: ei};
    cycle(acc);
    $display("drive instr=%h rs1=%h rs2=%h accepted=%b", instr, rs1, rs2, acc);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    logic acc;
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle(acc);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic        acc;
    logic        got;

    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_operand1", out_operand1, 32'd0);
    check("rst_operand2", out_operand2, 32'd0);
    check("rst_alu_control", {28'd0, out_alu_control}, 32'h2);
    check("rst_illegal", {31'd0, out_illegal}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    out_ready = 1'b1;
    send(32'h002081B3, 32'd5, 32'd7, 32'd5, 32'd7, 4'b0010, 1'b0);
    idle(1);

    // Back-to-back stream: each cycle pushes and pops at occupancy 1.
    send(32'hFFF08193, 32'd1, 32'd9, 32'd1, 32'hFFFFFFFF, 4'b0010, 1'b0);
    send(32'hFE20AE23, 32'h100, 32'd3, 32'h100, 32'hFFFFFFFC, 4'b0010, 1'b0);
    a = $urandom; b = $urandom;
    send(32'h402081B3, a, b, a, b, 4'b0110, 1'b0);
    a = $urandom; b = $urandom;
    send(32'h0020F1B3, a, b, a, b, 4'b0000, 1'b0);
    a = $urandom; b = $urandom;
    send(32'h0020E1B3, a, b, a, b, 4'b0001, 1'b0);
    a = $urandom; b = $urandom;
    send(32'h0020B1B3, a, b, a, b, 4'b0111, 1'b0);
    a = $urandom; b = $urandom;
    send(32'h00208063, a, b, a, b, 4'b0110, 1'b0);
    a = $urandom;
    send(32'h0080A183, a, 32'd0, a, 32'd8, 4'b0010, 1'b0);
    a = $urandom;
    send(32'h0F00F193, a, 32'd0, a, 32'h000000F0, 4'b0000, 1'b0);
    idle(2);

    send(32'h0000006F, 32'h1234, 32'h5678, 32'd0, 32'd0, 4'b0010, 1'b1);
`ifdef ALU_ISSUE_SLL_EN
    send(32'h00509193, 32'h33, 32'd0, 32'h33, 32'd5, 4'b1110, 1'b0);
    send(32'h002091B3, 32'h44, 32'd3, 32'h44, 32'd3, 4'b1110, 1'b0);
`else
    send(32'h00509193, 32'h33, 32'd0, 32'd0, 32'd0, 4'b0010, 1'b1);
    send(32'h002091B3, 32'h44, 32'd3, 32'd0, 32'd0, 4'b0010, 1'b1);
`endif
    idle(2);

    // Backpressure: two fill the FIFO, the third stalls until the ALU drains.
    out_ready = 1'b0;
    send(32'h002081B3, 32'd10, 32'd20, 32'd10, 32'd20, 4'b0010, 1'b0);
    send(32'h402081B3, 32'd30, 32'd40, 32'd30, 32'd40, 4'b0110, 1'b0);
    in_valid    = 1'b1;
    in_instr    = 32'h0020E1B3;
    in_rs1_data = 32'd50;
    in_rs2_data = 32'd60;
    pend = '{operand1: 32'd50, operand2: 32'd60, alu_control: 4'b0001, illegal: 1'b0};
    for (int i = 0; i < 4; i++) cycle(acc);
    check("stall_count", {30'd0, 2'(sb.size())}, 32'd2);
    out_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 5 && !got; i++) begin
      cycle(acc);
      got = acc;
    end
    check("third_accepted", {31'd0, got}, 32'd1);
    in_valid = 1'b0;
    idle(4);

    // Reset with two entries buffered.
    out_ready = 1'b0;
    send(32'h002081B3, 32'd1, 32'd2, 32'd1, 32'd2, 4'b0010, 1'b0);
    send(32'h002081B3, 32'd3, 32'd4, 32'd3, 32'd4, 4'b0010, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_operand1", out_operand1, 32'd0);
    check("midrst_operand2", out_operand2, 32'd0);
    check("midrst_alu_control", {28'd0, out_alu_control}, 32'h2);
    check("midrst_illegal", {31'd0, out_illegal}, 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle(3);

    // Drop-illegal instance: JAL is handshaken but never issued.
    in_instr = 32'h0000006F;
    in_valid_z = 1'b1;
    #1;
    check("drop_in_ready", {31'd0, in_ready_z}, 32'd1);
    @(negedge clk);
    in_valid_z = 1'b0;
    #1;
    check("drop_no_issue", {31'd0, out_valid_z}, 32'd0);
    @(negedge clk);
    #1;
    check("drop_no_issue2", {31'd0, out_valid_z}, 32'd0);
    @(negedge clk);
    in_instr    = 32'h002081B3;
    in_rs1_data = 32'd11;
    in_rs2_data = 32'd22;
    in_valid_z  = 1'b1;
    @(negedge clk);
    in_valid_z = 1'b0;
    #1;
    check("drop_legal_valid", {31'd0, out_valid_z}, 32'd1);
    check("drop_legal_op1", out_operand1_z, 32'd11);
    check("drop_legal_op2", out_operand2_z, 32'd22);
    check("drop_legal_ill", {31'd0, out_illegal_z}, 32'd0);
    @(negedge clk);
    #1;
    check("drop_drained", {31'd0, out_valid_z}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
